// File: rtl/syn_gpu_pxl_arb_n.sv
// syn_gpu_pxl_arb_n: N-channel round-robin pixel gateway arbiter onto one SRAM port.
// Outstanding reads are tracked in a tag FIFO that routes read data back to the issuer.
// Optional grant statistics are built when SYN_GPU_PXL_ARB_STATS_EN is defined;
// otherwise stat_gnt_cnt is tied to zero and stat_clr is ignored.
module syn_gpu_pxl_arb_n #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int TAG_D  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk_ir,
  input  logic                     rst_il,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_rd_wr_n,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_gnt,
  output logic [NUM_CH-1:0]        ch_rd_valid,
  output logic [DATA_W-1:0]        ch_rd_data,
  output logic                     sram_req,
  output logic                     sram_rd_wr_n,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic [DATA_W-1:0]        sram_wdata,
  input  logic                     sram_ack,
  input  logic                     sram_rd_valid,
  input  logic [DATA_W-1:0]        sram_rd_data,
  output logic                     tag_full,
  output logic                     err_unexp_rd,
  input  logic                     stat_clr,
  output logic [NUM_CH*CNT_W-1:0]  stat_gnt_cnt
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W  = (TAG_D > 1) ? $clog2(TAG_D) : 1;
  localparam int TCNT_W = $clog2(TAG_D + 1);
  localparam logic [TCNT_W-1:0] TAG_MAX = TCNT_W'(TAG_D);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                sram_req_q, sram_req_d;
  logic                sram_rd_wr_n_q, sram_rd_wr_n_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
  logic [TCNT_W-1:0]   tag_cnt_q, tag_cnt_d;
  logic [PTR_W-1:0]    tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CH_W-1:0]     tag_mem_q [TAG_D];
  logic [NUM_CH-1:0]   rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                err_q, err_d;

  logic [NUM_CH-1:0]   elig;
  logic                win_vld;
  logic [CH_W-1:0]     win_idx;
  logic                gnt_fire;
  logic                sel_rd;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                tag_push, tag_pop;

  // Eligibility and round-robin winner search starting at rr_ptr_q
  always_comb begin
    int cand;
    cand    = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      elig[i] = ch_req[i] & (~ch_rd_wr_n[i] | (tag_cnt_q < TAG_MAX));
    for (int k = 0; k < NUM_CH; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!win_vld && elig[CH_W'(cand)]) begin
        win_vld = 1'b1;
        win_idx = CH_W'(cand);
      end
    end
  end

  // Grant is offered when idle or when the held request is being accepted
  always_comb begin
    gnt_fire  = rst_il & win_vld & ((state_q == IDLE) | sram_ack);
    ch_gnt    = '0;
    sel_rd    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt_fire) ch_gnt[win_idx] = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_idx == CH_W'(i)) begin
        sel_rd    = ch_rd_wr_n[i];
        sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Issue FSM, tag FIFO bookkeeping and read-return routing next-state
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    sram_req_d     = sram_req_q;
    sram_rd_wr_n_d = sram_rd_wr_n_q;
    sram_addr_d    = sram_addr_q;
    sram_wdata_d   = sram_wdata_q;
    tag_push       = gnt_fire & sel_rd;
    tag_pop        = sram_rd_valid & (tag_cnt_q != '0);
    tag_cnt_d      = tag_cnt_q;
    tag_wr_d       = tag_wr_q;
    tag_rd_d       = tag_rd_q;
    rd_valid_d     = '0;
    rd_data_d      = rd_data_q;
    err_d          = err_q | (sram_rd_valid & (tag_cnt_q == '0));
    if (gnt_fire) begin
      state_d        = ISSUE;
      sram_req_d     = 1'b1;
      sram_rd_wr_n_d = sel_rd;
      sram_addr_d    = sel_addr;
      sram_wdata_d   = sel_wdata;
      rr_ptr_d       = (win_idx == CH_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
    end else if ((state_q == ISSUE) && sram_ack) begin
      state_d    = IDLE;
      sram_req_d = 1'b0;
    end
    case ({tag_push, tag_pop})
      2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
      2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
      default: tag_cnt_d = tag_cnt_q;
    endcase
    if (tag_push) tag_wr_d = tag_wr_q + 1'b1;
    if (tag_pop) begin
      tag_rd_d                        = tag_rd_q + 1'b1;
      rd_valid_d[tag_mem_q[tag_rd_q]] = 1'b1;
      rd_data_d                       = sram_rd_data;
    end
  end

  // Control and output registers
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      sram_req_q     <= 1'b0;
      sram_rd_wr_n_q <= 1'b0;
      sram_addr_q    <= '0;
      sram_wdata_q   <= '0;
      tag_cnt_q      <= '0;
      tag_wr_q       <= '0;
      tag_rd_q       <= '0;
      rd_valid_q     <= '0;
      rd_data_q      <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      sram_req_q     <= sram_req_d;
      sram_rd_wr_n_q <= sram_rd_wr_n_d;
      sram_addr_q    <= sram_addr_d;
      sram_wdata_q   <= sram_wdata_d;
      tag_cnt_q      <= tag_cnt_d;
      tag_wr_q       <= tag_wr_d;
      tag_rd_q       <= tag_rd_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      err_q          <= err_d;
    end
  end

  // Tag storage holds the issuing channel of each outstanding read
  always_ff @(posedge clk_ir) begin
    if (tag_push) tag_mem_q[tag_wr_q] <= win_idx;
  end

  assign sram_req     = sram_req_q;
  assign sram_rd_wr_n = sram_rd_wr_n_q;
  assign sram_addr    = sram_addr_q;
  assign sram_wdata   = sram_wdata_q;
  assign ch_rd_valid  = rd_valid_q;
  assign ch_rd_data   = rd_data_q;
  assign tag_full     = (tag_cnt_q == TAG_MAX);
  assign err_unexp_rd = err_q;

`ifdef SYN_GPU_PXL_ARB_STATS_EN
  logic [CNT_W-1:0] gcnt_q [NUM_CH];
  logic [CNT_W-1:0] gcnt_d [NUM_CH];

  // Saturating per-channel grant counters; clear has priority
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      gcnt_d[i] = gcnt_q[i];
      if (stat_clr)                        gcnt_d[i] = '0;
      else if (ch_gnt[i] && gcnt_q[i] != '1) gcnt_d[i] = gcnt_q[i] + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      for (int i = 0; i < NUM_CH; i++) gcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) gcnt_q[i] <= gcnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
    assign stat_gnt_cnt[g*CNT_W +: CNT_W] = gcnt_q[g];
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_gnt_cnt    = '0;
`endif

endmodule

// File: tb/tb_syn_gpu_pxl_arb_n.sv
// Randomized scoreboard bench for syn_gpu_pxl_arb_n with a queue-based reference model.
module tb_syn_gpu_pxl_arb_n;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int TAG_D  = 4;
  localparam int CNT_W  = 4;

  logic                     clk_ir = 1'b0;
  logic                     rst_il = 1'b0;
  logic [NUM_CH-1:0]        ch_req = '0;
  logic [NUM_CH-1:0]        ch_rd_wr_n = '0;
  logic [NUM_CH*ADDR_W-1:0] ch_addr = '0;
  logic [NUM_CH*DATA_W-1:0] ch_wdata = '0;
  logic [NUM_CH-1:0]        ch_gnt;
  logic [NUM_CH-1:0]        ch_rd_valid;
  logic [DATA_W-1:0]        ch_rd_data;
  logic                     sram_req;
  logic                     sram_rd_wr_n;
  logic [ADDR_W-1:0]        sram_addr;
  logic [DATA_W-1:0]        sram_wdata;
  logic                     sram_ack = 1'b0;
  logic                     sram_rd_valid = 1'b0;
  logic [DATA_W-1:0]        sram_rd_data = '0;
  logic                     tag_full;
  logic                     err_unexp_rd;
  logic                     stat_clr = 1'b0;
  logic [NUM_CH*CNT_W-1:0]  stat_gnt_cnt;

  syn_gpu_pxl_arb_n #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_D(TAG_D), .CNT_W(CNT_W)
  ) dut (
    .clk_ir(clk_ir), .rst_il(rst_il),
    .ch_req(ch_req), .ch_rd_wr_n(ch_rd_wr_n), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_gnt(ch_gnt), .ch_rd_valid(ch_rd_valid), .ch_rd_data(ch_rd_data),
    .sram_req(sram_req), .sram_rd_wr_n(sram_rd_wr_n), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_ack(sram_ack), .sram_rd_valid(sram_rd_valid),
    .sram_rd_data(sram_rd_data), .tag_full(tag_full), .err_unexp_rd(err_unexp_rd),
    .stat_clr(stat_clr), .stat_gnt_cnt(stat_gnt_cnt)
  );

  always #5 clk_ir = ~clk_ir;

  typedef struct { bit rd; bit [ADDR_W-1:0] addr; bit [DATA_W-1:0] wdata; } txn_t;
  typedef struct { int ch; bit [DATA_W-1:0] data; } ret_t;
  typedef struct { int t; bit [DATA_W-1:0] data; } sret_t;

  txn_t  exp_txn_q[$];
  ret_t  exp_ret_q[$];
  sret_t sram_ret_q[$];
  int    tag_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_ret_t = 0;

  // Reference model state
  bit             m_busy, m_cur_rd, m_err;
  int             m_rr;
  bit [CNT_W-1:0] m_cnt [NUM_CH];
  bit             p_vld [NUM_CH];
  bit             p_rd [NUM_CH];
  bit [ADDR_W-1:0] p_addr [NUM_CH];
  bit [DATA_W-1:0] p_wdata [NUM_CH];

  // Stimulus knobs
  int req_pct, rd_pct, ack_pct, lat_max, clr_pct;
  bit force_spur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_eval();
    int win;
    int c;
    int t;
    logic [NUM_CH-1:0] exp_gnt;
    logic [NUM_CH*CNT_W-1:0] exp_stat;
    win = -1;
    if (!m_busy || sram_ack) begin
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_rr + k) % NUM_CH;
        if (win < 0 && p_vld[c] && (!p_rd[c] || tag_q.size() < TAG_D)) win = c;
      end
    end
    exp_gnt = '0;
    if (win >= 0) exp_gnt[win] = 1'b1;
    for (int i = 0; i < NUM_CH; i++) exp_stat[i*CNT_W +: CNT_W] = m_cnt[i];
    check("ch_gnt", 64'(ch_gnt), 64'(exp_gnt));
    check("sram_req", 64'(sram_req), 64'(m_busy));
    check("tag_full", 64'(tag_full), 64'(tag_q.size() == TAG_D));
    check("err_unexp_rd", 64'(err_unexp_rd), 64'(m_err));
    check("stat_gnt_cnt", 64'(stat_gnt_cnt), 64'(exp_stat));
    // SRAM accepts the held request: schedule read return in order
    if (m_busy && sram_ack && m_cur_rd) begin
      t = cyc + int'($urandom_range(lat_max, 1));
      if (t <= last_ret_t) t = last_ret_t + 1;
      last_ret_t = t;
      sram_ret_q.push_back('{t: t, data: DATA_W'($urandom)});
    end
    // Read data returning from SRAM goes to the oldest outstanding reader
    if (sram_rd_valid) begin
      if (tag_q.size() > 0) exp_ret_q.push_back('{ch: tag_q.pop_front(), data: sram_rd_data});
      else m_err = 1'b1;
    end
    if (win >= 0) begin
      exp_txn_q.push_back('{rd: p_rd[win], addr: p_addr[win], wdata: p_wdata[win]});
      m_cur_rd = p_rd[win];
      m_busy = 1'b1;
      m_rr = (win + 1) % NUM_CH;
      if (p_rd[win]) tag_q.push_back(win);
      p_vld[win] = 1'b0;
    end else if (m_busy && sram_ack) begin
      m_busy = 1'b0;
    end
`ifdef SYN_GPU_PXL_ARB_STATS_EN
    if (stat_clr) begin
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = '0;
    end else if (win >= 0 && m_cnt[win] != {CNT_W{1'b1}}) begin
      m_cnt[win] = m_cnt[win] + 1'b1;
    end
`endif
  endtask

  task automatic step();
    @(posedge clk_ir);
    #1;
    cyc++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!p_vld[i] && $urandom_range(99) < req_pct) begin
        p_vld[i]   = 1'b1;
        p_rd[i]    = ($urandom_range(99) < rd_pct);
        p_addr[i]  = ADDR_W'($urandom);
        p_wdata[i] = DATA_W'($urandom);
      end
      ch_req[i]                       = p_vld[i];
      ch_rd_wr_n[i]                   = p_rd[i];
      ch_addr[i*ADDR_W +: ADDR_W]     = p_addr[i];
      ch_wdata[i*DATA_W +: DATA_W]    = p_wdata[i];
    end
    sram_ack = ($urandom_range(99) < ack_pct);
    stat_clr = ($urandom_range(99) < clr_pct);
    if (sram_ret_q.size() > 0 && sram_ret_q[0].t <= cyc) begin
      sram_rd_valid = 1'b1;
      sram_rd_data  = sram_ret_q[0].data;
      void'(sram_ret_q.pop_front());
    end else begin
      sram_rd_valid = force_spur;
      sram_rd_data  = DATA_W'($urandom);
    end
    @(negedge clk_ir);
    model_eval();
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk_ir);
    #1;
    rst_il = 1'b0;
    ch_req = '0; sram_ack = 1'b0; sram_rd_valid = 1'b0; stat_clr = 1'b0;
    m_busy = 1'b0; m_err = 1'b0; m_rr = 0; m_cur_rd = 1'b0;
    tag_q.delete(); exp_txn_q.delete(); exp_ret_q.delete();
    for (int i = 0; i < NUM_CH; i++) begin m_cnt[i] = '0; p_vld[i] = 1'b0; end
    repeat (ncyc) begin
      @(negedge clk_ir);
      check("rst ch_gnt", 64'(ch_gnt), 64'd0);
      check("rst sram_req", 64'(sram_req), 64'd0);
      check("rst sram_addr", 64'({sram_rd_wr_n, sram_addr, sram_wdata}), 64'd0);
      check("rst ch_rd_valid", 64'({ch_rd_valid, ch_rd_data}), 64'd0);
      check("rst flags", 64'({tag_full, err_unexp_rd}), 64'd0);
      check("rst stat_gnt_cnt", 64'(stat_gnt_cnt), 64'd0);
      @(posedge clk_ir);
      #1;
    end
    rst_il = 1'b1;
  endtask

  // Monitor: compare SRAM-side fields and read returns against scoreboard queues
  always @(negedge clk_ir) begin
    if (rst_il && sram_req) begin
      if (exp_txn_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL sram_req_unexpected: got request addr 0x%0h with none expected", sram_addr);
      end else begin
        check("sram_rd_wr_n", 64'(sram_rd_wr_n), 64'(exp_txn_q[0].rd));
        check("sram_addr", 64'(sram_addr), 64'(exp_txn_q[0].addr));
        if (!exp_txn_q[0].rd) check("sram_wdata", 64'(sram_wdata), 64'(exp_txn_q[0].wdata));
        if (sram_ack) void'(exp_txn_q.pop_front());
      end
    end
    if (ch_rd_valid != '0) begin
      if (exp_ret_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL ch_rd_valid_unexpected: got 0x%0h with none expected", ch_rd_valid);
      end else begin
        check("ch_rd_valid", 64'(ch_rd_valid), 64'(1) << exp_ret_q[0].ch);
        check("ch_rd_data", 64'(ch_rd_data), 64'(exp_ret_q[0].data));
        void'(exp_ret_q.pop_front());
      end
    end
  end

  initial begin
    req_pct = 0; rd_pct = 0; ack_pct = 100; lat_max = 4; clr_pct = 0; force_spur = 1'b0;
    do_reset(3);

    // All channels writing, SRAM always accepting: strict rotation
    req_pct = 100; rd_pct = 0; ack_pct = 100;
    repeat (200) step();

    // Mixed random traffic with stalls and variable read latency
    req_pct = 40; rd_pct = 50; ack_pct = 70; lat_max = 6; clr_pct = 2;
    repeat (1500) step();

    // Read-heavy with slow returns to drive the tag FIFO full
    req_pct = 80; rd_pct = 85; ack_pct = 90; lat_max = 20;
    repeat (1000) step();

    // Long ack stall
    ack_pct = 0;
    repeat (12) step();
    ack_pct = 80;
    repeat (200) step();

    // Drain, then inject an unexpected read return
    req_pct = 0; ack_pct = 100;
    repeat (60) step();
    force_spur = (tag_q.size() == 0 && sram_ret_q.size() == 0);
    step();
    force_spur = 1'b0;
    repeat (10) step();

    // Reset in the middle of traffic; stale SRAM returns arrive afterwards
    req_pct = 70; rd_pct = 80; ack_pct = 80; lat_max = 10;
    repeat (300) step();
    do_reset(2);
    repeat (600) step();

    // Final drain so the scoreboard empties
    req_pct = 0; ack_pct = 100;
    repeat (60) step();
    check("exp_txn_q_empty", 64'(exp_txn_q.size()), 64'd0);
    check("exp_ret_q_empty", 64'(exp_ret_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
